pmic_fsm_core: RTL and testbench
================================

PMIC_FSM_CORE -- requirements
Module: pmic_fsm_core

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock, all state changes on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-low reset (0 = reset).
REQ-003 SHALL have port Low_BAT, input, 1 bit: 1 = battery below threshold.
REQ-004 SHALL have port Low_POW, input, 1 bit: 1 = external supply below threshold.
REQ-005 SHALL have port ON_OFF, input, 1 bit: level power request; 1 = on, 0 = off.
REQ-006 SHALL have port timeOut, input, 1 bit: expiry pulse from the external sequencing timer.
REQ-007 SHALL have port Mux_Sel, output, 1 bit: supply select; 0 = external, 1 = battery.
REQ-008 SHALL have port load, output, 1 bit: one-cycle timer reload strobe.
REQ-009 SHALL have port en, output, 1 bit: timer count enable.
REQ-010 SHALL have ports IO_LDO_EN, Analog_LDO_EN and Logic_LDO_EN, outputs, 1 bit each: LDO enables.
REQ-011 SHALL have port Ready, output, 1 bit: 1 = all rails up, system operational.

Function
REQ-012 SHALL register all outputs: every output changes only on the clk edge that updates the state.
REQ-013 SHALL implement the states OFF, IO_UP, ANA_UP, LOG_UP, ON, LOG_DN, ANA_DN, IO_DN and LOCKOUT.
REQ-014 SHALL define supply_ok as NOT(Low_BAT AND Low_POW).
REQ-015 SHALL register Mux_Sel from Low_POW every cycle in every state.
REQ-016 SHALL, on entry to any timed state (IO_UP, ANA_UP, LOG_UP, LOG_DN, ANA_DN, IO_DN), drive load=1, en=0 for the entry cycle, then load=0, en=1 until the state exits.
REQ-017 SHALL drive load=0, en=0 in OFF, ON and LOCKOUT.
REQ-018 SHALL advance a timed state only when timeOut=1 is sampled while en=1; timeOut SHALL be ignored in every other cycle.
REQ-019 SHALL apply the following rail enables per state: OFF and LOCKOUT all 0; IO_UP IO only; ANA_UP IO and Analog; LOG_UP all three; ON all three; LOG_DN IO and Analog; ANA_DN IO only; IO_DN none.
REQ-020 SHALL drive Ready=1 only in ON.
REQ-021 SHALL transition OFF -> IO_UP when ON_OFF=1 and supply_ok=1.
REQ-022 SHALL transition IO_UP -> ANA_UP, ANA_UP -> LOG_UP and LOG_UP -> ON on a qualified timeOut.
REQ-023 SHALL transition ON -> LOG_DN when ON_OFF=0.
REQ-024 SHALL transition LOG_DN -> ANA_DN, ANA_DN -> IO_DN and IO_DN -> OFF on a qualified timeOut.
REQ-025 SHALL, when ON_OFF=0 during a ramp-up, abort to the matching ramp-down state: IO_UP -> IO_DN, ANA_UP -> ANA_DN, LOG_UP -> LOG_DN; ON_OFF=0 SHALL take priority over a simultaneous timeOut.
REQ-026 SHALL ignore ON_OFF=1 during ramp-down; after reaching OFF, a power-up SHALL start no earlier than the next cycle.
REQ-027 SHALL, when supply_ok=0 in any state other than OFF and LOCKOUT, go directly to LOCKOUT on the next edge, clearing all rails and Ready; supply_ok=0 SHALL have the highest priority.
REQ-028 SHALL exit LOCKOUT to OFF only when ON_OFF=0 and supply_ok=1.
REQ-029 SHALL, in OFF with supply_ok=0, stay in OFF.
REQ-030 SHALL, on any illegal state encoding, go to OFF.

Reset
REQ-031 SHALL, while reset=0, force state OFF and all outputs (Mux_Sel, load, en, three LDO enables, Ready) to 0 immediately, independent of clk.
REQ-032 SHALL, on reset assertion mid-sequence, including in ON, drop all rails at once with no orderly power-down.
REQ-033 SHALL begin evaluating inputs on the first rising clk edge after reset returns to 1.

Verification
REQ-034 SHALL pass this case: reset=0 for 100 ns, inputs 0 -> all outputs 0; release, ON_OFF=0 -> stays OFF, outputs 0.
REQ-035 SHALL pass this case: ON_OFF=1, timeOut held 0 -> next edge IO_LDO_EN=1, load=1 for 1 cycle, then en=1 indefinitely with no further rail.
REQ-036 SHALL pass this case: ON_OFF=1 with three 1-cycle timeOut pulses while en=1 -> IO, then Analog, then Logic, then Ready=1 on the edge after the third pulse.
REQ-037 SHALL pass this case: from ON, ON_OFF=0 plus three timeOut pulses -> Ready=0 and Logic off, then Analog off, then IO off, then OFF.
REQ-038 SHALL pass this case: in ANA_UP, Low_POW=1 -> Mux_Sel=1 and sequence continues; then Low_BAT=1 -> LOCKOUT next edge, all rails 0; ON_OFF=1 keeps LOCKOUT; ON_OFF=0 with Low_BAT=0 -> OFF.
REQ-039 SHALL pass this case: ON_OFF=0 in ANA_UP -> ANA_DN (IO only) with load pulse; reset=0 in ON -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/pmic_fsm_core.sv
// Power-management sequencer: orders IO -> Analog -> Logic LDO bring-up and the reverse on power-down.
// Latency: inputs sampled on clk, every output is registered and reflects the new state on the same edge.
// No backpressure; the external timer's timeOut advances timed states only while en is high.
module pmic_fsm_core (
    input  logic clk,
    input  logic reset,
    input  logic Low_BAT,
    input  logic Low_POW,
    input  logic ON_OFF,
    input  logic timeOut,
    output logic Mux_Sel,
    output logic load,
    output logic en,
    output logic IO_LDO_EN,
    output logic Analog_LDO_EN,
    output logic Logic_LDO_EN,
    output logic Ready
);

    localparam logic [3:0] ST_OFF     = 4'd0;
    localparam logic [3:0] ST_IO_UP   = 4'd1;
    localparam logic [3:0] ST_ANA_UP  = 4'd2;
    localparam logic [3:0] ST_LOG_UP  = 4'd3;
    localparam logic [3:0] ST_ON      = 4'd4;
    localparam logic [3:0] ST_LOG_DN  = 4'd5;
    localparam logic [3:0] ST_ANA_DN  = 4'd6;
    localparam logic [3:0] ST_IO_DN   = 4'd7;
    localparam logic [3:0] ST_LOCKOUT = 4'd8;

    logic [3:0] state;
    logic [3:0] next_state;
    logic       supply_ok;
    logic       tmo_qual;
    logic       next_timed;

    // Only a brown-out on both sources at once counts as a supply failure.
    assign supply_ok = ~(Low_BAT & Low_POW);

    // The timer expiry is meaningful only once the timer is actually counting.
    assign tmo_qual = timeOut & en;

    // Next-state selection; supply failure outranks power-off, which outranks timer expiry.
    always_comb begin
        next_state = state;
        if (!supply_ok && (state != ST_OFF) && (state != ST_LOCKOUT)) begin
            next_state = ST_LOCKOUT;
        end else begin
            case (state)
                ST_OFF:     if (ON_OFF && supply_ok) next_state = ST_IO_UP;
                ST_IO_UP:   if (!ON_OFF) next_state = ST_IO_DN;
                            else if (tmo_qual) next_state = ST_ANA_UP;
                ST_ANA_UP:  if (!ON_OFF) next_state = ST_ANA_DN;
                            else if (tmo_qual) next_state = ST_LOG_UP;
                ST_LOG_UP:  if (!ON_OFF) next_state = ST_LOG_DN;
                            else if (tmo_qual) next_state = ST_ON;
                ST_ON:      if (!ON_OFF) next_state = ST_LOG_DN;
                ST_LOG_DN:  if (tmo_qual) next_state = ST_ANA_DN;
                ST_ANA_DN:  if (tmo_qual) next_state = ST_IO_DN;
                ST_IO_DN:   if (tmo_qual) next_state = ST_OFF;
                ST_LOCKOUT: if (!ON_OFF && supply_ok) next_state = ST_OFF;
                default:    next_state = ST_OFF;
            endcase
        end
    end

    // Timed states are the six ramp steps paced by the external timer.
    always_comb begin
        next_timed = 1'b0;
        case (next_state)
            ST_IO_UP, ST_ANA_UP, ST_LOG_UP,
            ST_LOG_DN, ST_ANA_DN, ST_IO_DN: next_timed = 1'b1;
            default:                        next_timed = 1'b0;
        endcase
    end

    // State and outputs register together so every output moves on the state-change edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= ST_OFF;
            Mux_Sel       <= 1'b0;
            load          <= 1'b0;
            en            <= 1'b0;
            IO_LDO_EN     <= 1'b0;
            Analog_LDO_EN <= 1'b0;
            Logic_LDO_EN  <= 1'b0;
            Ready         <= 1'b0;
        end else begin
            state   <= next_state;
            Mux_Sel <= Low_POW;
            // Entering a timed state (including abort hops between timed states) reloads the timer.
            load    <= next_timed && (next_state != state);
            en      <= next_timed && (next_state == state);
            IO_LDO_EN     <= (next_state == ST_IO_UP)  || (next_state == ST_ANA_UP) ||
                             (next_state == ST_LOG_UP) || (next_state == ST_ON)     ||
                             (next_state == ST_LOG_DN) || (next_state == ST_ANA_DN);
            Analog_LDO_EN <= (next_state == ST_ANA_UP) || (next_state == ST_LOG_UP) ||
                             (next_state == ST_ON)     || (next_state == ST_LOG_DN);
            Logic_LDO_EN  <= (next_state == ST_LOG_UP) || (next_state == ST_ON);
            Ready         <= (next_state == ST_ON);
        end
    end

endmodule

// File: tb/tb_pmic_fsm_core.sv
// Directed bench for pmic_fsm_core: power-up/down sequencing, aborts, lockout and reset.
// Each step drives inputs just after a rising edge, then checks outputs 1 ns after the next edge.
// Vectors are {ON_OFF, timeOut, Low_BAT, Low_POW, Mux_Sel, load, en, IO, ANA, LOG, Ready}.
module tb_pmic_fsm_core;

    logic clk = 1'b0;
    logic reset;
    logic Low_BAT, Low_POW, ON_OFF, timeOut;
    logic Mux_Sel, load, en, IO_LDO_EN, Analog_LDO_EN, Logic_LDO_EN, Ready;
    logic [6:0] outs;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign outs = {Mux_Sel, load, en, IO_LDO_EN, Analog_LDO_EN, Logic_LDO_EN, Ready};

    pmic_fsm_core dut (
        .clk(clk), .reset(reset), .Low_BAT(Low_BAT), .Low_POW(Low_POW),
        .ON_OFF(ON_OFF), .timeOut(timeOut), .Mux_Sel(Mux_Sel), .load(load),
        .en(en), .IO_LDO_EN(IO_LDO_EN), .Analog_LDO_EN(Analog_LDO_EN),
        .Logic_LDO_EN(Logic_LDO_EN), .Ready(Ready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; ON_OFF = 0; timeOut = 0; Low_BAT = 0; Low_POW = 0;
        #100;
        checks++;
        if (outs !== 7'b0000000) begin
            errors++; $display("FAIL reset_hold got %b want %b", outs, 7'b0000000);
        end
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (outs !== 7'b0000000) begin
                errors++; $display("FAIL reset_idle step %0d got %b want %b", i, outs, 7'b0000000);
            end
        end
    endtask

    task automatic test_ramp_hold();
        logic [10:0] v [0:4];
        v = '{{4'b1000, 7'b0101000}, {4'b1000, 7'b0011000}, {4'b1000, 7'b0011000},
              {4'b1000, 7'b0011000}, {4'b1000, 7'b0011000}};
        for (int i = 0; i < 5; i++) begin
            {ON_OFF, timeOut, Low_BAT, Low_POW} = v[i][10:7];
            tick();
            checks++;
            if (outs !== v[i][6:0]) begin
                errors++; $display("FAIL ramp_hold step %0d got %b want %b", i, outs, v[i][6:0]);
            end
        end
    endtask

    task automatic test_power_up();
        logic [10:0] v [0:5];
        v = '{{4'b1100, 7'b0101100},   // IO_UP -> ANA_UP
              {4'b1100, 7'b0011100},   // timeOut during load cycle ignored
              {4'b1100, 7'b0101110},   // ANA_UP -> LOG_UP
              {4'b1000, 7'b0011110},
              {4'b1100, 7'b0001111},   // LOG_UP -> ON
              {4'b1100, 7'b0001111}};  // timeOut ignored in ON
        for (int i = 0; i < 6; i++) begin
            {ON_OFF, timeOut, Low_BAT, Low_POW} = v[i][10:7];
            tick();
            checks++;
            if (outs !== v[i][6:0]) begin
                errors++; $display("FAIL power_up step %0d got %b want %b", i, outs, v[i][6:0]);
            end
        end
    endtask

    task automatic test_power_down();
        logic [10:0] v [0:7];
        v = '{{4'b0000, 7'b0101100},   // ON -> LOG_DN
              {4'b1000, 7'b0011100},   // ON_OFF=1 ignored on ramp-down
              {4'b1100, 7'b0101000},   // -> ANA_DN
              {4'b1000, 7'b0011000},
              {4'b1100, 7'b0100000},   // -> IO_DN
              {4'b1000, 7'b0010000},
              {4'b1100, 7'b0000000},   // -> OFF despite ON_OFF=1
              {4'b1000, 7'b0101000}};  // next cycle power-up starts
        for (int i = 0; i < 8; i++) begin
            {ON_OFF, timeOut, Low_BAT, Low_POW} = v[i][10:7];
            tick();
            checks++;
            if (outs !== v[i][6:0]) begin
                errors++; $display("FAIL power_down step %0d got %b want %b", i, outs, v[i][6:0]);
            end
        end
    endtask

    task automatic test_lockout();
        logic [10:0] v [0:10];
        v = '{{4'b1000, 7'b0011000},   // IO_UP counting
              {4'b1100, 7'b0101100},   // -> ANA_UP
              {4'b1001, 7'b1011100},   // Low_POW alone: Mux_Sel=1, sequence continues
              {4'b1011, 7'b1000000},   // both low -> LOCKOUT
              {4'b1001, 7'b1000000},   // ON_OFF=1 holds LOCKOUT
              {4'b0001, 7'b1000000},   // ON_OFF=0 and supply ok -> OFF
              {4'b1011, 7'b1000000},   // OFF with bad supply stays OFF
              {4'b1001, 7'b1101000},   // supply ok -> IO_UP
              {4'b0000, 7'b0100000},   // abort IO_UP -> IO_DN
              {4'b1100, 7'b0010000},   // timeOut in load cycle ignored
              {4'b1100, 7'b0000000}};  // -> OFF
        for (int i = 0; i < 11; i++) begin
            {ON_OFF, timeOut, Low_BAT, Low_POW} = v[i][10:7];
            tick();
            checks++;
            if (outs !== v[i][6:0]) begin
                errors++; $display("FAIL lockout step %0d got %b want %b", i, outs, v[i][6:0]);
            end
        end
    endtask

    task automatic test_abort();
        logic [10:0] v [0:9];
        v = '{{4'b1000, 7'b0101000},   // OFF -> IO_UP
              {4'b1000, 7'b0011000},
              {4'b1100, 7'b0101100},   // -> ANA_UP
              {4'b1000, 7'b0011100},
              {4'b0100, 7'b0101000},   // ON_OFF=0 beats timeOut: -> ANA_DN
              {4'b0000, 7'b0011000},
              {4'b0100, 7'b0100000},   // -> IO_DN
              {4'b0000, 7'b0010000},
              {4'b0100, 7'b0000000},   // -> OFF
              {4'b0000, 7'b0000000}};
        for (int i = 0; i < 10; i++) begin
            {ON_OFF, timeOut, Low_BAT, Low_POW} = v[i][10:7];
            tick();
            checks++;
            if (outs !== v[i][6:0]) begin
                errors++; $display("FAIL abort step %0d got %b want %b", i, outs, v[i][6:0]);
            end
        end
    endtask

    task automatic test_reset_in_on();
        logic [10:0] v [0:6];
        v = '{{4'b1001, 7'b1101000}, {4'b1001, 7'b1011000}, {4'b1101, 7'b1101100},
              {4'b1001, 7'b1011100}, {4'b1101, 7'b1101110}, {4'b1001, 7'b1011110},
              {4'b1101, 7'b1001111}};
        for (int i = 0; i < 7; i++) begin
            {ON_OFF, timeOut, Low_BAT, Low_POW} = v[i][10:7];
            tick();
            checks++;
            if (outs !== v[i][6:0]) begin
                errors++; $display("FAIL reach_on step %0d got %b want %b", i, outs, v[i][6:0]);
            end
        end
        timeOut = 0;
        #3 reset = 1'b0;
        #1;
        checks++;
        if (outs !== 7'b0000000) begin
            errors++; $display("FAIL async_reset_on got %b want %b", outs, 7'b0000000);
        end
        tick();
        checks++;
        if (outs !== 7'b0000000) begin
            errors++; $display("FAIL reset_held_edge got %b want %b", outs, 7'b0000000);
        end
        Low_POW = 0;
        #4 reset = 1'b1;
        tick();
        checks++;
        if (outs !== 7'b0101000) begin
            errors++; $display("FAIL first_edge_after_reset got %b want %b", outs, 7'b0101000);
        end
    endtask

    initial begin
        test_reset();
        test_ramp_hold();
        test_power_up();
        test_power_down();
        test_lockout();
        test_abort();
        test_reset_in_on();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
